// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the framed UART receiver
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int USER_PAR = 0;
  localparam int USER_FRM = 1;
  localparam int USER_BRK = 2;

  function automatic logic parity_bad(input logic data_xor, input logic sample,
                                      input parity_e mode);
    return (data_xor ^ sample) != (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// rtl/uart_sync_edge.sv - rx metastability synchroniser with falling-edge detect
module uart_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   q_d;

  // Flops preset to the idle-high line level so reset never fakes a start edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr  <= '1;
      q_d <= 1'b1;
    end else begin
      sr  <= {sr[SYNC_STAGES-2:0], d};
      q_d <= sr[SYNC_STAGES-1];
    end
  end

  assign q    = sr[SYNC_STAGES-1];
  assign fall = q_d & ~q;

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - UART receiver with parity/stop checks, stream output and overrun status
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 217,
  parameter int BITS_PER_WORD    = 8,
  parameter int PARITY_MODE      = 0,
  parameter int STOP_BITS        = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int W_CNT            = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic [2:0]               m_user,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overrun,
  output logic [W_CNT-1:0]         drop_cnt,
  input  logic                     err_clr
);

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam parity_e       PMODE     = parity_e'(PARITY_MODE[1:0]);

  logic                     rx_s;
  logic                     rx_fall;
  rx_state_e                state, state_nxt;
  logic [CW-1:0]            cnt;
  logic [BW-1:0]            bit_idx;
  logic                     stop_idx;
  logic [BITS_PER_WORD-1:0] shreg;
  logic                     par_s;
  logic                     frm;
  logic                     cnt_clr;
  logic                     sample;
  logic                     last_stop;
  logic                     frm_final;
  logic [2:0]               user_nxt;
  logic                     done;
  logic [BITS_PER_WORD-1:0] done_data;
  logic [2:0]               done_user;
  logic                     load;
  logic                     drop;

  uart_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (rx),
    .q   (rx_s),
    .fall(rx_fall)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    sample    = 1'b0;
    last_stop = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        // Still high at mid start bit: treat as a glitch.
        if (cnt == CNT_HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          sample  = 1'b1;
          cnt_clr = 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = (PMODE == PAR_NONE) ? STOP : PARITY;
        end
      end
      PARITY: begin
        if (cnt == CNT_FULL) begin
          sample    = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          sample  = 1'b1;
          cnt_clr = 1'b1;
          if (stop_idx == LAST_STOP) begin
            last_stop = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are evaluated against the stop sample being taken this cycle.
  always_comb begin
    frm_final          = frm | ~rx_s;
    user_nxt           = '0;
    user_nxt[USER_PAR] = (PMODE != PAR_NONE) && parity_bad(^shreg, par_s, PMODE);
    user_nxt[USER_FRM] = frm_final;
    user_nxt[USER_BRK] = frm_final && (shreg == '0) && ((PMODE == PAR_NONE) || !par_s);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_s     <= 1'b0;
      frm       <= 1'b0;
      done      <= 1'b0;
      done_data <= '0;
      done_user <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (cnt_clr || state == IDLE) ? '0 : cnt + 1'b1;
      done  <= last_stop;
      if (state == IDLE) begin
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        frm      <= 1'b0;
      end else if (sample) begin
        case (state)
          DATA: begin
            shreg   <= {rx_s, shreg[BITS_PER_WORD-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          PARITY: par_s <= rx_s;
          STOP: begin
            if (!rx_s) frm <= 1'b1;
            stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
      if (last_stop) begin
        done_data <= shreg;
        done_user <= user_nxt;
      end
    end
  end

  assign load = done && (!m_valid || m_ready);
  assign drop = done && m_valid && !m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data   <= '0;
      m_user   <= '0;
      m_valid  <= 1'b0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        m_data  <= done_data;
        m_user  <= done_user;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (err_clr) drop_cnt <= '0;
      else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - scoreboard bench for uart_rx_framed in three frame formats
module tb_uart_rx_framed;

  localparam int CPP  = 4;
  localparam int HALF = CPP / 2;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] user;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [2:0] rx;
  logic [2:0] m_ready;
  logic [2:0] err_clr;
  logic [2:0] m_valid;
  logic [2:0] overrun;
  logic [7:0] m_data   [3];
  logic [2:0] m_user   [3];
  logic [7:0] drop_cnt [3];

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Instance 0: 8N1, instance 1: 8E1, instance 2: 8N2.
  uart_rx_framed #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PARITY_MODE(0), .STOP_BITS(1))
  dut0 (.clk(clk), .rstn(rstn), .rx(rx[0]), .m_data(m_data[0]), .m_user(m_user[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .overrun(overrun[0]),
        .drop_cnt(drop_cnt[0]), .err_clr(err_clr[0]));

  uart_rx_framed #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PARITY_MODE(1), .STOP_BITS(1))
  dut1 (.clk(clk), .rstn(rstn), .rx(rx[1]), .m_data(m_data[1]), .m_user(m_user[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .overrun(overrun[1]),
        .drop_cnt(drop_cnt[1]), .err_clr(err_clr[1]));

  uart_rx_framed #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PARITY_MODE(0), .STOP_BITS(2))
  dut2 (.clk(clk), .rstn(rstn), .rx(rx[2]), .m_data(m_data[2]), .m_user(m_user[2]),
        .m_valid(m_valid[2]), .m_ready(m_ready[2]), .overrun(overrun[2]),
        .drop_cnt(drop_cnt[2]), .err_clr(err_clr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_bit(input int d, input logic v);
    rx[d] = v;
    repeat (CPP) @(negedge clk);
  endtask

  // Even parity only on the parity instance; expected flags come from the frame definition.
  task automatic send_frame(input int d, input logic [7:0] data, input bit has_par,
                            input logic par, input int nstop, input logic [1:0] stops,
                            input bit push);
    exp_t e;
    logic frm;
    frm = 1'b0;
    for (int i = 0; i < nstop; i++) if (!stops[i]) frm = 1'b1;
    e.data = data;
    e.user[0] = has_par && ((^data) ^ par);
    e.user[1] = frm;
    e.user[2] = frm && (data == 8'h00) && (!has_par || !par);
    if (push) q.push_back(e);
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, data[i]);
    if (has_par) drive_bit(d, par);
    for (int i = 0; i < nstop; i++) drive_bit(d, stops[i]);
    rx[d] = 1'b1;
  endtask

  task automatic wait_valid(input int d, input int budget, output bit seen);
    seen = 1'b0;
    repeat (budget) begin
      @(negedge clk);
      if (m_valid[d]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total += 5;
      if (m_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", d, m_valid[d]); end
      if (m_data[d] !== 8'h00) begin bad++; $display("FAIL reset_data[%0d]: got %h want 00", d, m_data[d]); end
      if (m_user[d] !== 3'b000) begin bad++; $display("FAIL reset_user[%0d]: got %b want 000", d, m_user[d]); end
      if (overrun[d] !== 1'b0) begin bad++; $display("FAIL reset_overrun[%0d]: got %b want 0", d, overrun[d]); end
      if (drop_cnt[d] !== 8'h00) begin bad++; $display("FAIL reset_drop_cnt[%0d]: got %0d want 0", d, drop_cnt[d]); end
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int   lat;
    int   want;
    bit   seen;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    want = 2 + HALF + 9 * CPP + 1;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, 1'b1);
      begin
        repeat (200) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (m_valid[0]) begin
            seen = 1'b1;
            break;
          end
        end
      end
    join
    total++;
    if (!seen) begin
      bad++; $display("FAIL basic_timeout: got no m_valid want word");
    end else begin
      e = q.pop_front();
      total += 3;
      if (lat < want - 1 || lat > want + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d+-1", lat, want); end
      if (m_data[0] !== e.data) begin bad++; $display("FAIL basic_data: got %h want %h", m_data[0], e.data); end
      if (m_user[0] !== e.user) begin bad++; $display("FAIL basic_user: got %b want %b", m_user[0], e.user); end
      @(negedge clk);
      total++;
      if (m_valid[0] !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", m_valid[0]); end
    end
  endtask

  task automatic test_parity;
    bit   seen;
    exp_t e;
    fork
      begin
        send_frame(1, 8'h03, 1'b1, 1'b0, 1, 2'b01, 1'b1);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1, 2'b01, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_valid(1, 200, seen);
          total++;
          if (!seen) begin
            bad++; $display("FAIL parity_timeout%0d: got no m_valid want word", k);
          end else begin
            e = q.pop_front();
            total += 2;
            if (m_data[1] !== e.data) begin bad++; $display("FAIL parity_data%0d: got %h want %h", k, m_data[1], e.data); end
            if (m_user[1] !== e.user) begin bad++; $display("FAIL parity_user%0d: got %b want %b", k, m_user[1], e.user); end
          end
        end
      end
    join
    repeat (4) @(negedge clk);
  endtask

  task automatic test_stop_break;
    bit   seen;
    int   extra;
    exp_t e;
    fork
      send_frame(2, 8'h5A, 1'b0, 1'b0, 2, 2'b01, 1'b1);
      wait_valid(2, 200, seen);
    join
    total++;
    if (!seen) begin
      bad++; $display("FAIL frame_timeout: got no m_valid want word");
    end else begin
      e = q.pop_front();
      total += 2;
      if (m_data[2] !== e.data) begin bad++; $display("FAIL frame_data: got %h want %h", m_data[2], e.data); end
      if (m_user[2] !== e.user) begin bad++; $display("FAIL frame_user: got %b want %b", m_user[2], e.user); end
    end
    repeat (2 * CPP) @(negedge clk);
    e.data = 8'h00;
    e.user = 3'b110;
    q.push_back(e);
    seen = 1'b0;
    fork
      begin
        rx[2] = 1'b0;
        repeat (12 * CPP) @(negedge clk);
        rx[2] = 1'b1;
      end
      wait_valid(2, 200, seen);
    join
    total++;
    if (!seen) begin
      bad++; $display("FAIL break_timeout: got no m_valid want word");
    end else begin
      e = q.pop_front();
      total += 2;
      if (m_data[2] !== e.data) begin bad++; $display("FAIL break_data: got %h want %h", m_data[2], e.data); end
      if (m_user[2] !== e.user) begin bad++; $display("FAIL break_user: got %b want %b", m_user[2], e.user); end
    end
    extra = 0;
    repeat (16 * CPP) begin
      @(negedge clk);
      if (m_valid[2]) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL break_single: got %0d extra valid cycles want 0", extra); end
  endtask

  task automatic test_overrun;
    exp_t e;
    m_ready[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b01, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1, 2'b01, 1'b0);
    repeat (10) @(negedge clk);
    total += 4;
    if (m_valid[0] !== 1'b1) begin bad++; $display("FAIL ovr_valid: got %b want 1", m_valid[0]); end
    if (m_data[0] !== 8'h11) begin bad++; $display("FAIL ovr_data: got %h want 11", m_data[0]); end
    if (overrun[0] !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", overrun[0]); end
    if (drop_cnt[0] !== 8'd2) begin bad++; $display("FAIL ovr_drop_cnt: got %0d want 2", drop_cnt[0]); end
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    total += 3;
    if (overrun[0] !== 1'b0) begin bad++; $display("FAIL clr_flag: got %b want 0", overrun[0]); end
    if (drop_cnt[0] !== 8'd0) begin bad++; $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt[0]); end
    if (m_valid[0] !== 1'b1) begin bad++; $display("FAIL clr_hold: got %b want 1", m_valid[0]); end
    m_ready[0] = 1'b1;
    e = q.pop_front();
    total += 2;
    if (m_data[0] !== e.data) begin bad++; $display("FAIL accept_data: got %h want %h", m_data[0], e.data); end
    if (m_user[0] !== e.user) begin bad++; $display("FAIL accept_user: got %b want %b", m_user[0], e.user); end
    @(negedge clk);
    total++;
    if (m_valid[0] !== 1'b0) begin bad++; $display("FAIL accept_drop_valid: got %b want 0", m_valid[0]); end
  endtask

  task automatic test_glitch;
    int   hits;
    bit   seen;
    exp_t e;
    rx[0] = 1'b0;
    @(negedge clk);
    rx[0] = 1'b1;
    hits = 0;
    repeat (4 * CPP) begin
      @(negedge clk);
      if (m_valid[0]) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL glitch_emit: got %0d valid cycles want 0", hits); end
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b0, 1, 2'b01, 1'b1);
      wait_valid(0, 200, seen);
    join
    total++;
    if (!seen) begin
      bad++; $display("FAIL glitch_next_timeout: got no m_valid want word");
    end else begin
      e = q.pop_front();
      total += 2;
      if (m_data[0] !== e.data) begin bad++; $display("FAIL glitch_next_data: got %h want %h", m_data[0], e.data); end
      if (m_user[0] !== e.user) begin bad++; $display("FAIL glitch_next_user: got %b want %b", m_user[0], e.user); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int   hits;
    bit   seen;
    exp_t e;
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1, 2'b01, 1'b0);
      begin
        repeat (5 * CPP) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        total++;
        if (m_valid[0] !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", m_valid[0]); end
        rstn = 1'b1;
      end
    join
    hits = 0;
    repeat (6 * CPP) begin
      @(negedge clk);
      if (m_valid[0]) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL midrst_partial: got %0d valid cycles want 0", hits); end
    fork
      send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b01, 1'b1);
      wait_valid(0, 200, seen);
    join
    total++;
    if (!seen) begin
      bad++; $display("FAIL midrst_next_timeout: got no m_valid want word");
    end else begin
      e = q.pop_front();
      total += 2;
      if (m_data[0] !== e.data) begin bad++; $display("FAIL midrst_next_data: got %h want %h", m_data[0], e.data); end
      if (m_user[0] !== e.user) begin bad++; $display("FAIL midrst_next_user: got %b want %b", m_user[0], e.user); end
    end
  endtask

  initial begin
    rx      = 3'b111;
    m_ready = 3'b111;
    err_clr = 3'b000;
    rstn    = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_stop_break();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d words want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
